// File: rtl/csr_access_seq.sv
// CSR instruction sequencer: read-old / compute-new / write / respond for csrrd, csrwr and csrxchg.
// Build option: define CSR_XCHG_EN to enable the masked csrxchg write; otherwise op 10 is reserved.
module csr_access_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [13:0] req_num,
    input  logic [31:0] req_rd_val,
    input  logic [31:0] req_rj_val,
    input  logic [4:0]  req_rd_idx,
    output logic [13:0] csr_addr,
    input  logic [31:0] csr_rdata,
    output logic [13:0] csr_waddr,
    output logic        csr_wen,
    output logic [31:0] csr_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd_idx,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_XCHG = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [1:0]  op_q;
    logic [13:0] num_q;
    logic [31:0] rd_val_q;
    logic [4:0]  rd_idx_q;
    logic [31:0] old_q;
    logic [31:0] wdata_q;

    logic        is_write;
    logic        is_err;
    logic [31:0] new_val;

`ifdef CSR_XCHG_EN
    logic [31:0] rj_val_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_write = 1'b0;
        is_err   = 1'b0;
        new_val  = rd_val_q;
        case (op_q)
            OP_RD:   ;
            OP_WR:   is_write = 1'b1;
            OP_XCHG: begin
                is_write = 1'b1;
                // old value comes straight from the CSR file in READ, the cycle it is latched
                new_val  = (rd_val_q & rj_val_q) | (csr_rdata & ~rj_val_q);
            end
            OP_RSV:  is_err = 1'b1;
            default: is_err = 1'b1;
        endcase
    end
`else
    // rj only feeds the xchg mask, which does not exist in this build
    logic unused_rj_val;
    assign unused_rj_val = ^req_rj_val;

    always_comb begin
        is_write = (op_q == OP_WR);
        is_err   = op_q[1];
        new_val  = rd_val_q;
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req_valid) next_state = ST_READ;
            ST_READ:  next_state = is_write ? ST_WRITE : ST_RESP;
            ST_WRITE: next_state = ST_RESP;
            ST_RESP:  if (resp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_RD;
            num_q    <= '0;
            rd_val_q <= '0;
            rd_idx_q <= '0;
            old_q    <= '0;
            wdata_q  <= '0;
`ifdef CSR_XCHG_EN
            rj_val_q <= '0;
`endif
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        num_q    <= req_num;
                        rd_val_q <= req_rd_val;
                        rd_idx_q <= req_rd_idx;
`ifdef CSR_XCHG_EN
                        rj_val_q <= req_rj_val;
`endif
                    end
                end
                ST_READ: begin
                    // errored ops report 0 rather than the CSR contents
                    old_q <= is_err ? 32'd0 : csr_rdata;
                    if (is_write) wdata_q <= new_val;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign csr_addr    = num_q;
    assign csr_waddr   = num_q;
    assign csr_wen     = (state == ST_WRITE);
    assign csr_wdata   = wdata_q;
    assign resp_valid  = (state == ST_RESP);
    assign resp_rd_idx = rd_idx_q;
    assign resp_data   = old_q;
    assign resp_err    = (state == ST_RESP) && is_err;

endmodule

// File: tb/tb_csr_access_seq.sv
// Directed self-checking bench for csr_access_seq; inputs driven and outputs sampled on the falling edge.
module tb_csr_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [13:0] req_num;
    logic [31:0] req_rd_val;
    logic [31:0] req_rj_val;
    logic [4:0]  req_rd_idx;
    logic [13:0] csr_addr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd_idx;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wen_count = 0;

    csr_access_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_num(req_num),
        .req_rd_val(req_rd_val), .req_rj_val(req_rj_val), .req_rd_idx(req_rd_idx),
        .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
        .csr_wen(csr_wen), .csr_wdata(csr_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_idx(resp_rd_idx),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // counts every cycle in which a CSR write strobe is high
    always @(negedge clk) if (csr_wen !== 1'b0) wen_count++;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [13:0] num, input logic [31:0] rd_val,
                         input logic [31:0] rj_val, input logic [4:0] rd_idx);
        req_valid  = 1'b1;
        req_op     = op;
        req_num    = num;
        req_rd_val = rd_val;
        req_rj_val = rj_val;
        req_rd_idx = rd_idx;
        step();
        req_valid  = 1'b0;
    endtask

    int wen_before;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_num = '0; req_rd_val = '0;
        req_rj_val = '0; req_rd_idx = '0; csr_rdata = '0; resp_ready = 1'b1;
        step(); step();

        check("rst_req_ready",  32'(req_ready),   32'd1);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_csr_wen",    32'(csr_wen),     32'd0);
        check("rst_resp_valid", 32'(resp_valid),  32'd0);
        check("rst_resp_err",   32'(resp_err),    32'd0);
        check("rst_csr_addr",   32'(csr_addr),    32'd0);
        check("rst_csr_waddr",  32'(csr_waddr),   32'd0);
        check("rst_csr_wdata",  csr_wdata,        32'd0);
        check("rst_resp_data",  resp_data,        32'd0);
        check("rst_resp_rd_idx",32'(resp_rd_idx), 32'd0);
        rst = 1'b0;
        step();

        // csrrd: response in the second cycle after the accept cycle
        csr_rdata = 32'h0000_0008;
        issue(2'b00, 14'h000, 32'h0, 32'h0, 5'd3);
        check("rd_c1_resp_valid", 32'(resp_valid), 32'd0);
        check("rd_c1_busy",       32'(busy),       32'd1);
        check("rd_c1_req_ready",  32'(req_ready),  32'd0);
        step();
        check("rd_c2_resp_valid", 32'(resp_valid),  32'd1);
        check("rd_c2_resp_data",  resp_data,        32'h0000_0008);
        check("rd_c2_resp_err",   32'(resp_err),    32'd0);
        check("rd_c2_rd_idx",     32'(resp_rd_idx), 32'd3);
        step();
        check("rd_idle_req_ready", 32'(req_ready), 32'd1);
        check("rd_no_wen",         32'(wen_count), 32'd0);

        // csrwr: one write strobe, response one cycle later
        csr_rdata = 32'h1234_5678;
        issue(2'b01, 14'h030, 32'hDEAD_BEEF, 32'h0, 5'd5);
        check("wr_c1_csr_addr", 32'(csr_addr), 32'h030);
        check("wr_c1_wen",      32'(csr_wen),  32'd0);
        step();
        check("wr_c2_wen",   32'(csr_wen),   32'd1);
        check("wr_c2_waddr", 32'(csr_waddr), 32'h030);
        check("wr_c2_wdata", csr_wdata,      32'hDEAD_BEEF);
        check("wr_c2_resp_valid", 32'(resp_valid), 32'd0);
        step();
        check("wr_c3_wen",        32'(csr_wen),     32'd0);
        check("wr_c3_resp_valid", 32'(resp_valid),  32'd1);
        check("wr_c3_resp_data",  resp_data,        32'h1234_5678);
        check("wr_c3_rd_idx",     32'(resp_rd_idx), 32'd5);
        check("wr_c3_wdata_hold", csr_wdata,        32'hDEAD_BEEF);
        step();
        check("wr_wen_once", 32'(wen_count), 32'd1);

        // csrxchg: (0x00FF00FF & 0x0F0F0F0F) | (0xFFFF0000 & 0xF0F0F0F0) = 0x000F000F | 0xF0F00000
        csr_rdata = 32'hFFFF_0000;
        wen_before = wen_count;
        issue(2'b10, 14'h044, 32'h00FF_00FF, 32'h0F0F_0F0F, 5'd9);
        step();
`ifdef CSR_XCHG_EN
        check("xchg_c2_wen",   32'(csr_wen), 32'd1);
        check("xchg_c2_wdata", csr_wdata,    32'hF0FF_000F);
        step();
        check("xchg_c3_resp_valid", 32'(resp_valid), 32'd1);
        check("xchg_c3_resp_err",   32'(resp_err),   32'd0);
        check("xchg_c3_resp_data",  resp_data,       32'hFFFF_0000);
        step();
        check("xchg_wen_once", 32'(wen_count - wen_before), 32'd1);
`else
        check("xchg_c2_resp_valid", 32'(resp_valid), 32'd1);
        check("xchg_c2_resp_err",   32'(resp_err),   32'd1);
        check("xchg_c2_resp_data",  resp_data,       32'd0);
        step();
        check("xchg_no_wen", 32'(wen_count - wen_before), 32'd0);
`endif

        // stalled response: outputs hold and new requests are not captured
        csr_rdata  = 32'hA5A5_A5A5;
        resp_ready = 1'b0;
        issue(2'b00, 14'h010, 32'h0, 32'h0, 5'd7);
        step();
        csr_rdata  = 32'h0;
        req_valid  = 1'b1; req_op = 2'b01; req_num = 14'h3FF; req_rd_idx = 5'd30;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_resp_valid", 32'(resp_valid),  32'd1);
            check("stall_resp_data",  resp_data,        32'hA5A5_A5A5);
            check("stall_rd_idx",     32'(resp_rd_idx), 32'd7);
            check("stall_req_ready",  32'(req_ready),   32'd0);
            check("stall_csr_addr",   32'(csr_addr),    32'h010);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        check("stall_release_idle",  32'(req_ready),  32'd1);
        check("stall_release_valid", 32'(resp_valid), 32'd0);

        // reset while READ of a csrwr: no write and no response
        wen_before = wen_count;
        csr_rdata  = 32'h7777_7777;
        issue(2'b01, 14'h040, 32'hCAFE_F00D, 32'h0, 5'd2);
        rst = 1'b1;
        step();
        check("abort_wen",        32'(csr_wen),    32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready",  32'(req_ready),  32'd1);
        check("abort_csr_addr",   32'(csr_addr),   32'd0);
        rst = 1'b0;
        step(); step();
        check("abort_no_wen", 32'(wen_count - wen_before), 32'd0);
        check("abort_idle_resp_valid", 32'(resp_valid), 32'd0);

        // reserved op
        wen_before = wen_count;
        csr_rdata  = 32'h0000_0055;
        issue(2'b11, 14'h001, 32'h1111_1111, 32'h0, 5'd4);
        check("rsv_c1_resp_valid", 32'(resp_valid), 32'd0);
        step();
        check("rsv_c2_resp_valid", 32'(resp_valid), 32'd1);
        check("rsv_c2_resp_err",   32'(resp_err),   32'd1);
        check("rsv_c2_resp_data",  resp_data,       32'd0);
        step();
        check("rsv_no_wen",    32'(wen_count - wen_before), 32'd0);
        check("rsv_idle_err",  32'(resp_err),  32'd0);
        check("rsv_idle_ready",32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
